ex_muldiv_unit: RTL and testbench

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/ex_muldiv_unit_pkg.sv | 24 ++
 rtl/muldiv_div_core.sv | 55 +++++
 rtl/ex_muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32M funct3 encodings and operand-signedness helpers for the
// multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // rs1 is signed for MUL/MULH/MULHSU and for DIV/REM.
  function automatic logic rs1_signed(input logic [2:0] f3);
    return f3[2] ? !f3[0] : (f3[1:0] != 2'b11);
  endfunction

  // rs2 is signed for MUL/MULH and for DIV/REM.
  function automatic logic rs2_signed(input logic [2:0] f3);
    return f3[2] ? !f3[0] : !f3[1];
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per step;
// quotient/remainder outputs carry the sign correction.
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo, rem, dsr;
  logic            q_neg, r_neg;
  logic            n_neg, d_neg;
  logic [XLEN:0]   shifted, diff;

  assign n_neg   = is_signed & dividend[XLEN-1];
  assign d_neg   = is_signed & divisor[XLEN-1];
  // Dividend bits stream out of quo's MSB while quotient bits enter its LSB.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo   <= '0;
      rem   <= '0;
      dsr   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (load) begin
      quo   <= n_neg ? -dividend : dividend;
      rem   <= '0;
      dsr   <= d_neg ? -divisor : divisor;
      q_neg <= n_neg ^ d_neg;
      r_neg <= n_neg;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = q_neg ? -quo : quo;
  assign remainder = r_neg ? -rem : rem;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide execution unit with IDLE/MUL/DIV/DONE control.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier instead of shift-add.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  data1,
  input  logic [XLEN-1:0]  data2,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept, iter_done, finish;
  logic              mul_finish, div_finish, div_zero, div_ovf, is_rem;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_result, div_result, core_quo, core_rem;

  assign accept    = (state == S_IDLE) && start && !flush;
  assign iter_done = (cnt == CNT_W'(XLEN));
  assign div_zero  = (b_q == '0);
  assign div_ovf   = rs1_signed(op_q) && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign div_finish = div_zero || div_ovf || iter_done;
  assign finish    = !flush && (((state == S_MUL) && mul_finish) ||
                                ((state == S_DIV) && div_finish));

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first keeps this combinational block free of latches.
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = op[2] ? S_DIV : S_MUL;
        S_MUL:   if (mul_finish) state_nxt = S_DONE;
        S_DIV:   if (div_finish) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == S_MUL) || (state == S_DIV);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt     <= '0;
      result  <= '0;
      tag_out <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        a_q   <= data1;
        b_q   <= data2;
        tag_q <= tag_in;
        cnt   <= '0;
      end else if (busy && !iter_done) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        result  <= (state == S_DIV) ? div_result : mul_result;
        tag_out <= tag_q;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fprod;

  assign fa         = {rs1_signed(op_q) & a_q[XLEN-1], a_q};
  assign fb         = {rs2_signed(op_q) & b_q[XLEN-1], b_q};
  assign fprod      = fa * fb;
  assign product    = fprod[2*XLEN-1:0];
  assign mul_finish = 1'b1;
`else
  logic [2*XLEN-1:0] mcand, acc;
  logic [XLEN-1:0]   mplier;
  logic              mneg, ma_neg, mb_neg;

  assign ma_neg = rs1_signed(op) & data1[XLEN-1];
  assign mb_neg = rs2_signed(op) & data2[XLEN-1];

  // Shift-add over magnitudes; the product sign is restored at the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mneg   <= 1'b0;
    end else if (accept && !op[2]) begin
      mcand  <= {{XLEN{1'b0}}, (ma_neg ? -data1 : data1)};
      mplier <= mb_neg ? -data2 : data2;
      acc    <= '0;
      mneg   <= ma_neg ^ mb_neg;
    end else if ((state == S_MUL) && !iter_done) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign product    = mneg ? -acc : acc;
  assign mul_finish = iter_done;
`endif

  assign mul_result = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  assign is_rem     = (op_q == OP_REM) || (op_q == OP_REMU);

  always_comb begin
    if (div_zero)     div_result = is_rem ? a_q : '1;
    else if (div_ovf) div_result = is_rem ? '0 : a_q;
    else              div_result = is_rem ? core_rem : core_quo;
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && op[2]),
    .step      ((state == S_DIV) && !iter_done),
    .is_signed (rs1_signed(op)),
    .dividend  (data1),
    .divisor   (data2),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [XLEN-1:0]  data1 = '0;
  logic [XLEN-1:0]  data2 = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             flush = 1'b0;
  logic             busy, done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  int               n_checks = 0;
  int               n_pass = 0;
  logic [XLEN-1:0]  last_exp = '0;
  logic [TAG_W-1:0] last_tag = '0;

  ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .data1   (data1),
    .data2   (data2),
    .tag_in  (tag_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .tag_out (tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] zext(input logic [31:0] v);
    return {32'd0, v};
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'b000: begin p = sext(a) * sext(b); return p[31:0]; end
      3'b001: begin p = sext(a) * sext(b); return p[63:32]; end
      3'b010: begin p = sext(a) * zext(b); return p[63:32]; end
      3'b011: begin p = zext(a) * zext(b); return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return MUL_LAT;
    if (b == 0) return 2;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return DIV_LAT;
  endfunction

  // Launch one operation at a negedge, wait for done (bounded), check
  // latency/result/tag, then check the one-cycle pulse and held outputs.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input logic [31:0] exp_r, input int exp_l,
                        input int noise_at, input string name);
    int lat;
    bit seen;
    bit busy_ok;
    op = o; data1 = a; data2 = b; tag_in = t; start = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (noise_at != 0 && lat == noise_at) begin
        start = 1'b1; op = 3'($urandom); data1 = $urandom; data2 = $urandom;
        tag_in = TAG_W'($urandom);
      end
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    check($sformatf("%s.done_seen", name), 64'(seen), 64'd1);
    check($sformatf("%s.latency", name), 64'(lat), 64'(exp_l));
    check($sformatf("%s.result", name), 64'(result), 64'(exp_r));
    check($sformatf("%s.tag", name), 64'(tag_out), 64'(t));
    check($sformatf("%s.busy_at_done", name), 64'(busy), 64'd0);
    check($sformatf("%s.busy_while_running", name), 64'(busy_ok), 64'd1);
    @(negedge clk);
    check($sformatf("%s.done_pulse", name), 64'(done), 64'd0);
    check($sformatf("%s.result_held", name), 64'(result), 64'(exp_r));
    last_exp = exp_r;
    last_tag = t;
  endtask

  // Watch a number of cycles and report whether any done pulse appeared.
  task automatic watch_no_done(input int cycles, input string name);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.result", 64'(result), 64'd0);
    check("reset.tag", 64'(tag_out), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_op(3'b100, 32'd100, 32'd7, 5'd3, 32'd14, DIV_LAT, 0, "div_100_7");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, DIV_LAT, 0, "rem_m7_2");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, DIV_LAT, 0, "div_m7_2");
    run_op(3'b101, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 2, 0, "divu_by0");
    run_op(3'b111, 32'd5, 32'd0, 5'd7, 32'd5, 2, 0, "remu_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 2, 0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 2, 0, "rem_ovf");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'd0, MUL_LAT, 0, "mulh_m1");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, MUL_LAT, 0, "mulhu_max");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, MUL_LAT, 0, "mulhsu_m1");
    run_op(3'b100, 32'd100, 32'd7, 5'd3, 32'd14, DIV_LAT, 5, "div_start_ignored");
    run_op(3'b000, 32'd3, 32'd4, 5'd13, 32'd12, MUL_LAT, 0, "mul_3_4");

    // Flush in the middle of a divide.
    op = 3'b100; data1 = 32'd1000; data2 = 32'd3; tag_in = 5'd20; start = 1'b1;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_mid.busy", 64'(busy), 64'd0);
    watch_no_done(40, "flush_mid.no_done");
    check("flush_mid.result_held", 64'(result), 64'(last_exp));
    check("flush_mid.tag_held", 64'(tag_out), 64'(last_tag));

    // Flush wins over start in the same idle cycle.
    op = 3'b101; data1 = 32'd50; data2 = 32'd5; tag_in = 5'd21; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start.busy", 64'(busy), 64'd0);
    watch_no_done(40, "flush_start.no_done");

    // Asynchronous reset in the middle of a divide.
    op = 3'b101; data1 = 32'hDEAD_BEEF; data2 = 32'd3; tag_in = 5'd22; start = 1'b1;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.result", 64'(result), 64'd0);
    check("rst_mid.tag", 64'(tag_out), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch_no_done(40, "rst_mid.no_done");
    run_op(3'b101, 32'd9, 32'd3, 5'd23, 32'd3, DIV_LAT, 0, "divu_9_3_after_rst");

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      int          sel;
      ro  = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, TAG_W'($urandom), ref_result(ro, ra, rb), ref_latency(ro, ra, rb),
             0, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
